mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the single-ported unified memory between the instruction-fetch port and the load/store data port.
//  - Arbitrates between the two ports with round-robin priority.
//  - Sequences each access through a fixed-latency issue/capture/acknowledge cycle.
//  - Rejects illegal data accesses (misaligned, bad size, store into instruction region) before they reach memory.
//  - Sits between the multi-cycle control/datapath and the memory block.
// PARAMETERS
//  BUS_WIDTH    32  address/data width
//  MEM_LATENCY  1   cycles from issue until mem_out_val is sampled (>=1)
//  I_MEM_SIZE   64  stores with address < I_MEM_SIZE are illegal
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   asynchronous active-low reset
//  if_req         in   1   fetch request; hold with if_addr until if_ack
//  if_addr        in   32  fetch byte address
//  if_ack         out  1   1-cycle pulse: fetch complete
//  if_rdata       out  32  fetched word, valid with if_ack, held until next if_ack
//  if_err         out  1   with if_ack: fetch rejected (if_addr[1:0]!=0)
//  d_req          in   1   data request; hold d_* stable until d_ack
//  d_we           in   1   1=store, 0=load
//  d_addr         in   32  data byte address
//  d_wdata        in   32  store data
//  d_size         in   2   00 byte, 01 half, 10 word, 11 illegal
//  d_sz_ex        in   1   load sign(1)/zero(0) extend
//  d_ack          out  1   1-cycle pulse: data access complete
//  d_rdata        out  32  load data, valid with d_ack; held until the next load ack
//  d_err          out  1   with d_ack: access rejected, memory untouched
//  mem_address    out  32  to memory address
//  mem_wr_en      out  1   to memory write enable
//  mem_in_val     out  32  to memory write data
//  mem_size       out  2   to memory access size
//  mem_sz_ex_sel  out  1   to memory sign/zero extend select
//  mem_out_val    in   32  from memory read data
//  busy           out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, last_gnt=DATA.
//    All outputs 0, including rdata registers and mem_* outputs.
//  - FSM states: IDLE, ACCESS, DONE.
//  - IDLE, neither req asserted: stay IDLE.
//  - IDLE, one req asserted: grant that port.
//  - IDLE, both req asserted: grant the port != last_gnt; the first grant after reset goes to fetch.
//  - On grant: last_gnt<=port.
//    - Legal access: latch command into mem_* registers, cnt<=1, go to ACCESS.
//    - Illegal access: go directly to DONE with err=1; no mem_wr_en, mem_* remain 0.
//  - Illegal data access is any of:
//    - d_size=11;
//    - half with addr[0]=1;
//    - word with addr[1:0]!=0;
//    - store with d_addr < I_MEM_SIZE.
//  - Fetch access: always size=10, sz_ex=0, wr_en=0.
//  - ACCESS: mem_* held stable. mem_wr_en=1 only in the first ACCESS cycle, and only for a store.
//    - cnt<MEM_LATENCY: cnt++.
//    - cnt==MEM_LATENCY: capture mem_out_val into the granted port's rdata (loads/fetches only); go to DONE.
//  - DONE: the granted port's ack=1 for exactly one cycle; mem_* outputs return to 0; next state IDLE.
//  - Latency: grant edge at cycle 0 -> ack high in cycle MEM_LATENCY+1 (legal) or cycle 1 (illegal).
//  - At most one access outstanding; ack never asserts on both ports in the same cycle.
//  - Requester drops req in the cycle after ack. If req is still high when the FSM returns to IDLE, it is a new request (back-to-back allowed, subject to round-robin).
//  - Requests changing while busy are ignored until IDLE; requests arriving in DONE are arbitrated in the following IDLE cycle.
//  - Store completion leaves d_rdata unchanged; err=0 on every legal ack.
//  - Reset mid-ACCESS: immediate return to IDLE, mem_wr_en=0, no ack is ever issued for the aborted access.
// TESTING
//  1 Fetch, MEM_LATENCY=1, if_addr=0x40, mem_out_val=0x00A00093 -> mem_address=0x40, size=10 in cycle 1; if_ack + if_rdata=0x00A00093 in cycle 2; busy 1 for cycles 1-2.
//  2 if_req and d_req (load 0x80) both high after reset -> fetch acked first, then load; d_rdata=mem word; no overlap of acks; repeated contention alternates grants.
//  3 Store word 0xDEADBEEF to 0x80 -> mem_wr_en=1 for exactly one cycle with mem_in_val=0xDEADBEEF; d_ack, d_err=0; d_rdata unchanged.
//  4 Illegal data accesses: store to 0x3C; word load from 0x81; d_size=11 -> each gives d_ack=1 and d_err=1 one cycle after grant; mem_wr_en stays 0.
//  5 Byte load with d_sz_ex=1, d_addr=0x83 -> mem_size=00, mem_sz_ex_sel=1 during ACCESS; d_rdata=mem_out_val sampled at cnt==MEM_LATENCY (repeat with MEM_LATENCY=3: ack in cycle 4).
//  6 rst asserted mid-ACCESS of a store -> all outputs 0 asynchronously, no ack; after release, pending if_req is granted first.

Source files
------------

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (fetch, load/store) and the memory block.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface mem_access_arbiter_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 if_req;
  logic [BUS_WIDTH-1:0] if_addr;
  logic                 if_ack;
  logic [BUS_WIDTH-1:0] if_rdata;
  logic                 if_err;

  logic                 d_req;
  logic                 d_we;
  logic [BUS_WIDTH-1:0] d_addr;
  logic [BUS_WIDTH-1:0] d_wdata;
  logic [1:0]           d_size;
  logic                 d_sz_ex;
  logic                 d_ack;
  logic [BUS_WIDTH-1:0] d_rdata;
  logic                 d_err;

  logic [BUS_WIDTH-1:0] mem_address;
  logic                 mem_wr_en;
  logic [BUS_WIDTH-1:0] mem_in_val;
  logic [1:0]           mem_size;
  logic                 mem_sz_ex_sel;
  logic [BUS_WIDTH-1:0] mem_out_val;

  logic                 busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_size, d_sz_ex,
    input  mem_out_val,
    output if_ack, if_rdata, if_err,
    output d_ack, d_rdata, d_err,
    output mem_address, mem_wr_en, mem_in_val, mem_size, mem_sz_ex_sel,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_size, d_sz_ex,
    output mem_out_val,
    input  if_ack, if_rdata, if_err,
    input  d_ack, d_rdata, d_err,
    input  mem_address, mem_wr_en, mem_in_val, mem_size, mem_sz_ex_sel,
    input  busy
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and load/store,
// with fixed-latency issue/capture/ack sequencing and up-front rejection of illegal data accesses.
module mem_access_arbiter #(
  parameter int BUS_WIDTH   = 32,
  parameter int MEM_LATENCY = 1,
  parameter int I_MEM_SIZE  = 64
) (
  input logic                 clk,
  input logic                 rst,
  mem_access_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int                   CW          = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]        CNT_LAST    = CW'(MEM_LATENCY);
  localparam logic [BUS_WIDTH-1:0] I_MEM_LIMIT = BUS_WIDTH'(I_MEM_SIZE);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 gnt_q, gnt_d;
  logic                 err_q, err_d;
  logic                 store_q, store_d;
  logic [BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic [BUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 mem_sz_ex_q, mem_sz_ex_d;
  logic [BUS_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [BUS_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic grant;
  logic d_illegal;
  logic if_illegal;

  assign if_illegal = (bus.if_addr[1:0] != 2'b00);
  assign d_illegal  = (bus.d_size == 2'b11)
                   || (bus.d_size == 2'b01 && bus.d_addr[0])
                   || (bus.d_size == 2'b10 && bus.d_addr[1:0] != 2'b00)
                   || (bus.d_we && bus.d_addr < I_MEM_LIMIT);

  // On contention the port that did not win last time gets the grant.
  assign grant = (bus.if_req && bus.d_req) ? ~last_gnt_q : bus.d_req;

  always_comb begin
    // NOTE: every next-state value takes its held value first so no branch can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    err_d       = err_q;
    store_d     = store_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_en_d = mem_wr_en_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_sz_ex_d = mem_sz_ex_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          last_gnt_d = grant;
          gnt_d      = grant;
          err_d      = (grant == PORT_DATA) ? d_illegal : if_illegal;
          store_d    = (grant == PORT_DATA) && bus.d_we;
          if (err_d) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = CW'(1);
            if (grant == PORT_DATA) begin
              mem_addr_d  = bus.d_addr;
              mem_wr_en_d = bus.d_we;
              mem_wdata_d = bus.d_wdata;
              mem_size_d  = bus.d_size;
              mem_sz_ex_d = bus.d_sz_ex;
            end else begin
              mem_addr_d  = bus.if_addr;
              mem_wr_en_d = 1'b0;
              mem_wdata_d = '0;
              mem_size_d  = 2'b10;
              mem_sz_ex_d = 1'b0;
            end
          end
        end
      end

      ST_ACCESS: begin
        mem_wr_en_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          if (gnt_q == PORT_FETCH) if_rdata_d = bus.mem_out_val;
          else if (!store_q)       d_rdata_d  = bus.mem_out_val;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_size_d  = 2'b00;
          mem_sz_ex_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= PORT_DATA;
      gnt_q       <= PORT_FETCH;
      err_q       <= 1'b0;
      store_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wr_en_q <= 1'b0;
      mem_wdata_q <= '0;
      mem_size_q  <= 2'b00;
      mem_sz_ex_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge value of its peers.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      store_q     <= store_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_sz_ex_q <= mem_sz_ex_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_ack        = (state_q == ST_DONE) && (gnt_q == PORT_FETCH);
  assign bus.d_ack         = (state_q == ST_DONE) && (gnt_q == PORT_DATA);
  assign bus.if_err        = bus.if_ack && err_q;
  assign bus.d_err         = bus.d_ack && err_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.mem_address   = mem_addr_q;
  assign bus.mem_wr_en     = mem_wr_en_q;
  assign bus.mem_in_val    = mem_wdata_q;
  assign bus.mem_size      = mem_size_q;
  assign bus.mem_sz_ex_sel = mem_sz_ex_q;
  assign bus.busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: one DUT at MEM_LATENCY=1, one at MEM_LATENCY=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_access_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_arbiter_if #(.BUS_WIDTH(32)) bus1 ();
  mem_access_arbiter_if #(.BUS_WIDTH(32)) bus3 ();

  mem_access_arbiter #(.BUS_WIDTH(32), .MEM_LATENCY(1), .I_MEM_SIZE(64)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  mem_access_arbiter #(.BUS_WIDTH(32), .MEM_LATENCY(3), .I_MEM_SIZE(64)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        exp_err;
  } dvec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0;
    bus1.d_wdata = 0; bus1.d_size = 0; bus1.d_sz_ex = 0; bus1.mem_out_val = 0;
    bus3.if_req = 0; bus3.if_addr = 0; bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = 0;
    bus3.d_wdata = 0; bus3.d_size = 0; bus3.d_sz_ex = 0; bus3.mem_out_val = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [136:0] o1, o3;
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    o1 = {bus1.if_ack, bus1.if_err, bus1.if_rdata, bus1.d_ack, bus1.d_err, bus1.d_rdata, bus1.mem_address,
          bus1.mem_wr_en, bus1.mem_in_val, bus1.mem_size, bus1.mem_sz_ex_sel, bus1.busy};
    o3 = {bus3.if_ack, bus3.if_err, bus3.if_rdata, bus3.d_ack, bus3.d_err, bus3.d_rdata, bus3.mem_address,
          bus3.mem_wr_en, bus3.mem_in_val, bus3.mem_size, bus3.mem_sz_ex_sel, bus3.busy};
    total++; if (o1 !== '0) begin bad++; $display("FAIL reset_outputs_lat1 got=%h want=0", o1); end
    total++; if (o3 !== '0) begin bad++; $display("FAIL reset_outputs_lat3 got=%h want=0", o3); end
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    bus1.if_addr = 32'h40; bus1.mem_out_val = 32'h00A00093; bus1.if_req = 1;
    step();  // cycle 1
    total++; if (bus1.mem_address !== 32'h40) begin bad++; $display("FAIL fetch_addr got=%h want=40", bus1.mem_address); end
    total++; if (bus1.mem_size !== 2'b10) begin bad++; $display("FAIL fetch_size got=%b want=10", bus1.mem_size); end
    total++; if (bus1.busy !== 1'b1 || bus1.if_ack !== 1'b0) begin bad++; $display("FAIL fetch_c1 busy=%b ack=%b want 1/0", bus1.busy, bus1.if_ack); end
    step();  // cycle 2
    total++; if (bus1.if_ack !== 1'b1 || bus1.if_err !== 1'b0) begin bad++; $display("FAIL fetch_ack ack=%b err=%b want 1/0", bus1.if_ack, bus1.if_err); end
    total++; if (bus1.if_rdata !== 32'h00A00093) begin bad++; $display("FAIL fetch_rdata got=%h want=00a00093", bus1.if_rdata); end
    total++; if (bus1.busy !== 1'b1 || bus1.mem_address !== 32'h0) begin bad++; $display("FAIL fetch_done busy=%b addr=%h want 1/0", bus1.busy, bus1.mem_address); end
    bus1.if_req = 0; bus1.mem_out_val = 32'h0;
    step();  // cycle 3
    total++; if (bus1.busy !== 1'b0 || bus1.if_ack !== 1'b0) begin bad++; $display("FAIL fetch_idle busy=%b ack=%b want 0/0", bus1.busy, bus1.if_ack); end
    total++; if (bus1.if_rdata !== 32'h00A00093) begin bad++; $display("FAIL fetch_hold got=%h want=00a00093", bus1.if_rdata); end

    bus1.if_addr = 32'h42; bus1.if_req = 1;
    step();
    total++; if (bus1.if_ack !== 1'b1 || bus1.if_err !== 1'b1) begin bad++; $display("FAIL fetch_misalign ack=%b err=%b want 1/1", bus1.if_ack, bus1.if_err); end
    total++; if (bus1.mem_address !== 32'h0 || bus1.if_rdata !== 32'h00A00093) begin bad++; $display("FAIL fetch_misalign_mem addr=%h rdata=%h", bus1.mem_address, bus1.if_rdata); end
    bus1.if_req = 0;
    step();
  endtask

  task automatic test_contention();
    int  seen;
    int  waited;
    logic port;
    do_reset();
    bus1.if_addr = 32'h44; bus1.d_addr = 32'h80; bus1.d_we = 0; bus1.d_size = 2'b10;
    bus1.mem_out_val = 32'h11111111; bus1.if_req = 1; bus1.d_req = 1;
    step();  // cycle 1
    total++; if (bus1.mem_address !== 32'h44) begin bad++; $display("FAIL rr_first_fetch addr=%h want=44", bus1.mem_address); end
    step();  // cycle 2
    total++; if (bus1.if_ack !== 1'b1 || bus1.d_ack !== 1'b0) begin bad++; $display("FAIL rr_fetch_ack if=%b d=%b want 1/0", bus1.if_ack, bus1.d_ack); end
    total++; if (bus1.if_rdata !== 32'h11111111) begin bad++; $display("FAIL rr_fetch_rdata got=%h want=11111111", bus1.if_rdata); end
    bus1.if_req = 0; bus1.mem_out_val = 32'h22222222;
    step();  // cycle 3
    total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL rr_idle busy=%b want=0", bus1.busy); end
    step();  // cycle 4
    total++; if (bus1.mem_address !== 32'h80) begin bad++; $display("FAIL rr_load_addr got=%h want=80", bus1.mem_address); end
    step();  // cycle 5
    total++; if (bus1.d_ack !== 1'b1 || bus1.if_ack !== 1'b0 || bus1.d_err !== 1'b0) begin bad++; $display("FAIL rr_load_ack d=%b if=%b err=%b want 1/0/0", bus1.d_ack, bus1.if_ack, bus1.d_err); end
    total++; if (bus1.d_rdata !== 32'h22222222) begin bad++; $display("FAIL rr_load_rdata got=%h want=22222222", bus1.d_rdata); end

    // Both requests held continuously: grants must alternate fetch, data, fetch, data.
    bus1.if_req = 1;
    seen = 0;
    waited = 0;
    while (seen < 4 && waited < 40) begin
      step();
      waited++;
      if (bus1.if_ack === 1'b1 && bus1.d_ack === 1'b1) begin
        total++; bad++; $display("FAIL rr_ack_overlap if=1 d=1 want one");
      end else if (bus1.if_ack === 1'b1 || bus1.d_ack === 1'b1) begin
        port = bus1.d_ack;
        total++; if (port !== ((seen % 2) == 1)) begin bad++; $display("FAIL rr_alternate ack%0d got_data=%b want_data=%b", seen, port, (seen % 2) == 1); end
        seen++;
      end
    end
    total++; if (seen != 4) begin bad++; $display("FAIL rr_timeout acks=%0d want=4", seen); end
    bus1.if_req = 0; bus1.d_req = 0;
    step();
    step();
  endtask

  task automatic test_store();
    bus1.d_addr = 32'h80; bus1.d_we = 1; bus1.d_wdata = 32'hDEADBEEF; bus1.d_size = 2'b10;
    bus1.mem_out_val = 32'h33333333; bus1.d_req = 1;
    step();  // cycle 1
    total++; if (bus1.mem_wr_en !== 1'b1 || bus1.mem_in_val !== 32'hDEADBEEF) begin bad++; $display("FAIL store_issue we=%b wdata=%h want 1/deadbeef", bus1.mem_wr_en, bus1.mem_in_val); end
    total++; if (bus1.mem_address !== 32'h80) begin bad++; $display("FAIL store_addr got=%h want=80", bus1.mem_address); end
    step();  // cycle 2
    total++; if (bus1.mem_wr_en !== 1'b0) begin bad++; $display("FAIL store_we_pulse got=%b want=0", bus1.mem_wr_en); end
    total++; if (bus1.d_ack !== 1'b1 || bus1.d_err !== 1'b0) begin bad++; $display("FAIL store_ack ack=%b err=%b want 1/0", bus1.d_ack, bus1.d_err); end
    total++; if (bus1.d_rdata !== 32'h22222222) begin bad++; $display("FAIL store_rdata_hold got=%h want=22222222", bus1.d_rdata); end
    bus1.d_req = 0; bus1.d_we = 0;
    step();
  endtask

  task automatic test_illegal();
    dvec_t v [5];
    v[0] = '{1'b1, 32'h3C, 2'b10, 1'b1};
    v[1] = '{1'b0, 32'h81, 2'b10, 1'b1};
    v[2] = '{1'b0, 32'h80, 2'b11, 1'b1};
    v[3] = '{1'b0, 32'h81, 2'b01, 1'b1};
    v[4] = '{1'b1, 32'h40, 2'b10, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus1.d_we = v[i].we; bus1.d_addr = v[i].addr; bus1.d_size = v[i].size;
      bus1.d_wdata = 32'hCAFE0000 + i; bus1.d_req = 1;
      step();  // cycle 1
      if (v[i].exp_err) begin
        total++; if (bus1.d_ack !== 1'b1 || bus1.d_err !== 1'b1) begin bad++; $display("FAIL illegal%0d ack=%b err=%b want 1/1", i, bus1.d_ack, bus1.d_err); end
        total++; if (bus1.mem_wr_en !== 1'b0 || bus1.mem_address !== 32'h0) begin bad++; $display("FAIL illegal%0d_mem we=%b addr=%h want 0/0", i, bus1.mem_wr_en, bus1.mem_address); end
      end else begin
        total++; if (bus1.d_ack !== 1'b0 || bus1.mem_wr_en !== v[i].we) begin bad++; $display("FAIL legal%0d_issue ack=%b we=%b want 0/%b", i, bus1.d_ack, bus1.mem_wr_en, v[i].we); end
        step();  // cycle 2
        total++; if (bus1.d_ack !== 1'b1 || bus1.d_err !== 1'b0) begin bad++; $display("FAIL legal%0d_ack ack=%b err=%b want 1/0", i, bus1.d_ack, bus1.d_err); end
      end
      bus1.d_req = 0;
      step();
    end
    bus1.d_we = 0;
  endtask

  task automatic test_byte_load();
    bus1.d_addr = 32'h83; bus1.d_we = 0; bus1.d_size = 2'b00; bus1.d_sz_ex = 1;
    bus1.mem_out_val = 32'hFFFFFF80; bus1.d_req = 1;
    step();  // cycle 1
    total++; if (bus1.mem_size !== 2'b00 || bus1.mem_sz_ex_sel !== 1'b1 || bus1.mem_address !== 32'h83) begin bad++; $display("FAIL byte_issue size=%b sx=%b addr=%h want 00/1/83", bus1.mem_size, bus1.mem_sz_ex_sel, bus1.mem_address); end
    step();  // cycle 2
    total++; if (bus1.d_ack !== 1'b1 || bus1.d_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_ack ack=%b rdata=%h want 1/ffffff80", bus1.d_ack, bus1.d_rdata); end
    bus1.d_req = 0; bus1.d_sz_ex = 0;
    step();

    bus3.d_addr = 32'h83; bus3.d_we = 0; bus3.d_size = 2'b00; bus3.d_sz_ex = 1;
    bus3.mem_out_val = 32'hAAAAAAAA; bus3.d_req = 1;
    step();  // cycle 1
    total++; if (bus3.mem_size !== 2'b00 || bus3.mem_sz_ex_sel !== 1'b1 || bus3.busy !== 1'b1) begin bad++; $display("FAIL lat3_issue size=%b sx=%b busy=%b want 00/1/1", bus3.mem_size, bus3.mem_sz_ex_sel, bus3.busy); end
    step();  // cycle 2
    total++; if (bus3.d_ack !== 1'b0) begin bad++; $display("FAIL lat3_c2_ack got=%b want=0", bus3.d_ack); end
    step();  // cycle 3
    total++; if (bus3.d_ack !== 1'b0 || bus3.mem_sz_ex_sel !== 1'b1) begin bad++; $display("FAIL lat3_c3 ack=%b sx=%b want 0/1", bus3.d_ack, bus3.mem_sz_ex_sel); end
    bus3.mem_out_val = 32'hFFFFFF85;
    step();  // cycle 4
    total++; if (bus3.d_ack !== 1'b1 || bus3.d_rdata !== 32'hFFFFFF85) begin bad++; $display("FAIL lat3_ack ack=%b rdata=%h want 1/ffffff85", bus3.d_ack, bus3.d_rdata); end
    bus3.d_req = 0; bus3.d_sz_ex = 0;
    step();
  endtask

  task automatic test_reset_mid_access();
    logic [136:0] o1;
    bus1.d_addr = 32'h100; bus1.d_we = 1; bus1.d_wdata = 32'h12345678; bus1.d_size = 2'b10;
    bus1.if_addr = 32'h48; bus1.mem_out_val = 32'h0; bus1.d_req = 1;
    step();  // cycle 1, store in ACCESS
    total++; if (bus1.mem_wr_en !== 1'b1) begin bad++; $display("FAIL rstmid_issue we=%b want=1", bus1.mem_wr_en); end
    #2;
    rst = 1'b0;
    bus1.if_req = 1;
    #1;
    o1 = {bus1.if_ack, bus1.if_err, bus1.if_rdata, bus1.d_ack, bus1.d_err, bus1.d_rdata, bus1.mem_address,
          bus1.mem_wr_en, bus1.mem_in_val, bus1.mem_size, bus1.mem_sz_ex_sel, bus1.busy};
    total++; if (o1 !== '0) begin bad++; $display("FAIL rstmid_async got=%h want=0", o1); end
    step();
    total++; if (bus1.d_ack !== 1'b0 || bus1.busy !== 1'b0) begin bad++; $display("FAIL rstmid_held ack=%b busy=%b want 0/0", bus1.d_ack, bus1.busy); end
    rst = 1'b1;
    step();  // cycle 1 after release
    total++; if (bus1.mem_address !== 32'h48 || bus1.d_ack !== 1'b0) begin bad++; $display("FAIL rstmid_regrant addr=%h dack=%b want 48/0", bus1.mem_address, bus1.d_ack); end
    step();  // cycle 2
    total++; if (bus1.if_ack !== 1'b1 || bus1.d_ack !== 1'b0) begin bad++; $display("FAIL rstmid_fetch_ack if=%b d=%b want 1/0", bus1.if_ack, bus1.d_ack); end
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_illegal();
    test_byte_load();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
